// File: rtl/callret_pkg.sv
// Shared types and helpers for the call/return controller.
package callret_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    POP_WAIT     = 2'd1,
    RET_REDIRECT = 2'd2
  } state_e;

  function automatic int cap_f(input int depth_width);
    return 1 << depth_width;
  endfunction

endpackage

// File: rtl/call_return_ctrl_if.sv
// Decode-side and stack-side signals of the call/return controller.
interface call_return_ctrl_if #(
  parameter int IA_WIDTH    = 12,
  parameter int D_WIDTH     = 34,
  parameter int DEPTH_WIDTH = 5
);
  logic                  valid_i;
  logic                  is_call_i;
  logic                  is_ret_i;
  logic [IA_WIDTH-1:0]   pc_i;
  logic [IA_WIDTH-1:0]   target_i;
  logic [D_WIDTH-1:0]    pop_data_i;
  logic                  stack_we_o;
  logic                  stack_push_o;
  logic [D_WIDTH-1:0]    stack_wdata_o;
  logic                  redirect_valid_o;
  logic [IA_WIDTH-1:0]   redirect_pc_o;
  logic                  stall_o;
  logic [DEPTH_WIDTH:0]  depth_o;
  logic                  full_o;
  logic                  empty_o;

  modport master (
    output valid_i, is_call_i, is_ret_i, pc_i, target_i, pop_data_i,
    input  stack_we_o, stack_push_o, stack_wdata_o, redirect_valid_o,
           redirect_pc_o, stall_o, depth_o, full_o, empty_o
  );

  modport slave (
    input  valid_i, is_call_i, is_ret_i, pc_i, target_i, pop_data_i,
    output stack_we_o, stack_push_o, stack_wdata_o, redirect_valid_o,
           redirect_pc_o, stall_o, depth_o, full_o, empty_o
  );
endinterface

// File: rtl/callret_depth_ctr.sv
// Saturating stack occupancy counter, bounded to 0..CAP.
module callret_depth_ctr
  import callret_pkg::*;
#(
  parameter int DEPTH_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 dec,
  output logic [DEPTH_WIDTH:0] depth,
  output logic                 full,
  output logic                 empty
);
  localparam logic [DEPTH_WIDTH:0] CAP = (DEPTH_WIDTH+1)'(cap_f(DEPTH_WIDTH));
  localparam logic [DEPTH_WIDTH:0] ONE = (DEPTH_WIDTH+1)'(1);

  always_ff @(posedge clk) begin
    if (reset)                           depth <= '0;
    else if (inc && !dec && depth != CAP) depth <= depth + ONE;
    else if (dec && !inc && depth != '0)  depth <= depth - ONE;
  end

  assign full  = (depth == CAP);
  assign empty = (depth == '0);
endmodule

// File: rtl/call_return_ctrl.sv
// Call/return controller: pushes return addresses, pops them on ret and redirects the PC.
// Optional CALLRET_FAULT_EN adds fault_o / fault_sticky_o for overflow and underflow.
module call_return_ctrl
  import callret_pkg::*;
#(
  parameter int IA_WIDTH    = 12,
  parameter int D_WIDTH     = 34,
  parameter int DEPTH_WIDTH = 5
) (
  input  logic               clk,
  input  logic               reset,
  call_return_ctrl_if.slave  bus
`ifdef CALLRET_FAULT_EN
  ,
  output logic               fault_o,
  output logic               fault_sticky_o
`endif
);
  state_e              state_q, state_d;
  logic                we_q, we_d, push_q, push_d, rv_q, rv_d, stall_q, stall_d;
  logic [D_WIDTH-1:0]  wdata_q, wdata_d;
  logic [IA_WIDTH-1:0] rpc_q, rpc_d, ret_addr;
  logic                inc, dec, full, empty;
  logic                unused_pop_hi;
`ifdef CALLRET_FAULT_EN
  logic                fault_d, fault_q, sticky_q;
`endif

  assign ret_addr      = bus.pc_i + IA_WIDTH'(1);
  assign unused_pop_hi = ^bus.pop_data_i;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    push_d  = 1'b0;
    wdata_d = '0;
    rv_d    = 1'b0;
    rpc_d   = '0;
    stall_d = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
`ifdef CALLRET_FAULT_EN
    fault_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (bus.valid_i) begin
        if (bus.is_call_i) begin
          if (!full) begin
            we_d    = 1'b1;
            push_d  = 1'b1;
            wdata_d = D_WIDTH'(ret_addr);
            rv_d    = 1'b1;
            rpc_d   = bus.target_i;
            inc     = 1'b1;
          end else begin
`ifdef CALLRET_FAULT_EN
            fault_d = 1'b1;
`else
            // overflow: drop the push but still follow the call
            rv_d    = 1'b1;
            rpc_d   = bus.target_i;
`endif
          end
        end else if (bus.is_ret_i) begin
          if (!empty) begin
            we_d    = 1'b1;
            dec     = 1'b1;
            stall_d = 1'b1;
            state_d = POP_WAIT;
          end else begin
`ifdef CALLRET_FAULT_EN
            fault_d = 1'b1;
`endif
          end
        end
      end
      POP_WAIT: begin
        stall_d = 1'b1;
        state_d = RET_REDIRECT;
      end
      RET_REDIRECT: begin
        rv_d    = 1'b1;
        rpc_d   = bus.pop_data_i[IA_WIDTH-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      push_q  <= 1'b0;
      wdata_q <= '0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      push_q  <= push_d;
      wdata_q <= wdata_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      stall_q <= stall_d;
    end
  end

`ifdef CALLRET_FAULT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      fault_q  <= fault_d;
      sticky_q <= sticky_q | fault_d;
    end
  end
  assign fault_o        = fault_q;
  assign fault_sticky_o = sticky_q;
`endif

  callret_depth_ctr #(.DEPTH_WIDTH(DEPTH_WIDTH)) u_depth (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .dec   (dec),
    .depth (bus.depth_o),
    .full  (full),
    .empty (empty)
  );

  assign bus.full_o           = full;
  assign bus.empty_o          = empty;
  assign bus.stack_we_o       = we_q;
  assign bus.stack_push_o     = push_q;
  assign bus.stack_wdata_o    = wdata_q;
  assign bus.redirect_valid_o = rv_q;
  assign bus.redirect_pc_o    = rpc_q;
  assign bus.stall_o          = stall_q;
endmodule

// File: doc/call_return_ctrl.md
CALL_RETURN_CTRL -- requirements
Module: call_return_ctrl

Interface
REQ-001 SHALL have parameter IA_WIDTH, default 12, instruction address width.
REQ-002 SHALL have parameter D_WIDTH, default 34, stack data width; must be at least IA_WIDTH.
REQ-003 SHALL have parameter DEPTH_WIDTH, default 5, stack pointer width; capacity CAP = 2**DEPTH_WIDTH entries.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 valid_i  input  1  decoded instruction valid this cycle.
REQ-008 is_call_i  input  1  instruction is a call.
REQ-009 is_ret_i  input  1  instruction is a return.
REQ-010 pc_i  input  IA_WIDTH  address of the current instruction.
REQ-011 target_i  input  IA_WIDTH  call target address.
REQ-012 pop_data_i  input  D_WIDTH  top-of-stack data returned by the downstream stack.
REQ-013 stack_we_o  output  1  stack operation strobe, one cycle per operation.
REQ-014 stack_push_o  output  1  1 = push, 0 = pop; valid while stack_we_o=1.
REQ-015 stack_wdata_o  output  D_WIDTH  data to push.
REQ-016 redirect_valid_o  output  1  one-cycle PC redirect strobe.
REQ-017 redirect_pc_o  output  IA_WIDTH  redirect address.
REQ-018 stall_o  output  1  upstream must hold the instruction; inputs are ignored while high.
REQ-019 depth_o  output  DEPTH_WIDTH+1  current number of stacked entries.
REQ-020 full_o / empty_o  output  1 each  depth_o==CAP / depth_o==0.

Function
REQ-021 SHALL implement the FSM states IDLE, POP_WAIT and RET_REDIRECT, with all outputs registered.
REQ-022 In IDLE, valid_i & is_call_i & !full_o SHALL, next cycle, drive stack_we_o=1, stack_push_o=1, stack_wdata_o=zero-extended (pc_i+1) mod 2**IA_WIDTH, redirect_valid_o=1 and redirect_pc_o=target_i, and SHALL increment depth_o; the FSM stays in IDLE.
REQ-023 In IDLE, valid_i & is_ret_i & !is_call_i & !empty_o SHALL, next cycle, drive stack_we_o=1, stack_push_o=0 and stack_wdata_o=0, decrement depth_o, enter POP_WAIT and assert stall_o.
REQ-024 POP_WAIT SHALL last one cycle with stall_o=1, then enter RET_REDIRECT.
REQ-025 RET_REDIRECT SHALL capture pop_data_i[IA_WIDTH-1:0], drive redirect_valid_o=1 with that value as redirect_pc_o and stall_o=0, and return to IDLE; return latency from the ret cycle to the redirect is 3 cycles.
REQ-026 If is_call_i and is_ret_i are both set, the call SHALL take priority.
REQ-027 Overflow (a call while full_o) SHALL suppress the push, leave depth_o unchanged and still issue the redirect to target_i.
REQ-028 Underflow (a ret while empty_o) SHALL be ignored: no pop, no stall, no redirect.
REQ-029 stack_we_o and redirect_valid_o SHALL be 0 in every cycle without an accepted operation.
REQ-030 Depth arithmetic SHALL never wrap: the count is bounded to 0..CAP.

Reset
REQ-031 Reset SHALL force IDLE, depth_o=0, empty_o=1, and all other outputs to 0 on the next edge.
REQ-032 Reset during POP_WAIT or RET_REDIRECT SHALL abort the pending redirect; reset dominates all inputs in the same cycle.
REQ-033 The downstream stack SHALL share the same reset, so both blocks return to empty together.

Configuration
REQ-034 Macro CALLRET_FAULT_EN SHALL add output fault_o (1 bit) and output fault_sticky_o (1 bit).
REQ-035 With CALLRET_FAULT_EN, overflow or underflow SHALL pulse fault_o for one cycle and set fault_sticky_o until reset; an overflow call SHALL also suppress its redirect.
REQ-036 Without CALLRET_FAULT_EN, the ports SHALL be absent and REQ-027 and REQ-028 behaviour is unchanged.

Structure
REQ-037 Shared package callret_pkg SHALL hold the FSM state enum typedef and the CAP-computation function.
REQ-038 The depth counter SHALL be a sub-module callret_depth_ctr with inc/dec inputs and saturation at 0 and CAP.

Verification
REQ-039 Call: pc_i=0x010, target_i=0x200 -> next cycle we=1, push=1, wdata=0x011, redirect 0x200, depth_o=1.
REQ-040 Call then ret with pop_data_i=0x011 -> we=1, push=0; stall_o high for 2 cycles; redirect 0x011 on cycle 3; depth_o=0.
REQ-041 32 calls (DEPTH_WIDTH=5) then a 33rd -> full_o=1, no 33rd push, redirect still issued; with the macro, fault_o pulses and there is no redirect.
REQ-042 Ret at depth 0 -> no we, no stall, no redirect; with the macro, fault_o and fault_sticky_o are set.
REQ-043 Reset asserted in POP_WAIT -> no redirect; next cycle IDLE, depth_o=0, all outputs 0.
REQ-044 is_call_i=is_ret_i=1 with pc_i=0xFFF -> push of wdata=0x000 (wrap), redirect to target_i.
